// File: rtl/control_sequencer_if.sv
// Control bundle of the microcoded CPU sequencer: instruction/flag/mode
// inputs toward the sequencer and the decoded control lines back out.
interface control_sequencer_if;
  logic       prog_mode;
  logic [3:0] opcode;
  logic       carry_flag;
  logic       zero_flag;
  logic       mi_n;
  logic       ro_n;
  logic       ii_n;
  logic       io_n;
  logic       ai_n;
  logic       ao_n;
  logic       eo_n;
  logic       bi_n;
  logic       oi_n;
  logic       co_n;
  logic       j_n;
  logic       fi_n;
  logic       ri;
  logic       su;
  logic       ce;
  logic       hlt;
  logic [2:0] step;

  modport master (
    input  prog_mode, opcode, carry_flag, zero_flag,
    output mi_n, ro_n, ii_n, io_n, ai_n, ao_n, eo_n, bi_n, oi_n, co_n, j_n, fi_n,
    output ri, su, ce, hlt, step
  );

  modport slave (
    output prog_mode, opcode, carry_flag, zero_flag,
    input  mi_n, ro_n, ii_n, io_n, ai_n, ao_n, eo_n, bi_n, oi_n, co_n, j_n, fi_n,
    input  ri, su, ce, hlt, step
  );
endinterface

// File: rtl/control_sequencer.sv
// Five-step microinstruction sequencer. A step counter walks T0..T4 and the
// control lines are a purely combinational decode of the current step, the
// live opcode/flags, the halt latch and the run/program switch.
module control_sequencer (
  input  logic                clk,
  input  logic                clr,
  control_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_e;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  step_e step_q, step_d;
  logic  halt_q, halt_d;

  // Internal active-high control strobes, inverted at the port where needed
  logic c_mi, c_ro, c_ii, c_io, c_ai, c_ao, c_eo, c_bi, c_oi, c_co, c_j, c_fi;
  logic c_ri, c_su, c_ce, c_hlt;

  // State register: clr clears step and halt latch without waiting for clk
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      step_q <= T0;
      halt_q <= 1'b0;
    end else begin
      step_q <= step_d;
      halt_q <= halt_d;
    end
  end

  // Next state: halt freezes at T3, program mode parks at T0, else advance
  always_comb begin
    step_d = step_q;
    halt_d = halt_q;
    if (halt_q) begin
      step_d = T3;
    end else if (!bus.prog_mode) begin
      step_d = T0;
    end else begin
      case (step_q)
        T0: step_d = T1;
        T1: step_d = T2;
        T2: begin
          step_d = T3;
          if (bus.opcode == OP_HLT) halt_d = 1'b1;
        end
        T3: step_d = T4;
        T4: step_d = T0;
        default: step_d = T0;
      endcase
    end
  end

  // Control decode; everything idle while clearing, halted or programming
  always_comb begin
    c_mi  = 1'b0;
    c_ro  = 1'b0;
    c_ii  = 1'b0;
    c_io  = 1'b0;
    c_ai  = 1'b0;
    c_ao  = 1'b0;
    c_eo  = 1'b0;
    c_bi  = 1'b0;
    c_oi  = 1'b0;
    c_co  = 1'b0;
    c_j   = 1'b0;
    c_fi  = 1'b0;
    c_ri  = 1'b0;
    c_su  = 1'b0;
    c_ce  = 1'b0;
    c_hlt = 1'b0;
    if (!clr && !halt_q && bus.prog_mode) begin
      case (step_q)
        T0: begin
          c_co = 1'b1;
          c_mi = 1'b1;
        end
        T1: begin
          c_ro = 1'b1;
          c_ii = 1'b1;
          c_ce = 1'b1;
        end
        T2: begin
          case (bus.opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              c_io = 1'b1;
              c_mi = 1'b1;
            end
            OP_LDI: begin
              c_io = 1'b1;
              c_ai = 1'b1;
            end
            OP_JMP: begin
              c_io = 1'b1;
              c_j  = 1'b1;
            end
            OP_JC: begin
              c_io = bus.carry_flag;
              c_j  = bus.carry_flag;
            end
            OP_JZ: begin
              c_io = bus.zero_flag;
              c_j  = bus.zero_flag;
            end
            OP_OUT: begin
              c_ao = 1'b1;
              c_oi = 1'b1;
            end
            OP_HLT: c_hlt = 1'b1;
            default: ;
          endcase
        end
        T3: begin
          case (bus.opcode)
            OP_LDA: begin
              c_ro = 1'b1;
              c_ai = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              c_ro = 1'b1;
              c_bi = 1'b1;
            end
            OP_STA: begin
              c_ao = 1'b1;
              c_ri = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            c_eo = 1'b1;
            c_ai = 1'b1;
            c_fi = 1'b1;
            c_su = (bus.opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mi_n = ~c_mi;
  assign bus.ro_n = ~c_ro;
  assign bus.ii_n = ~c_ii;
  assign bus.io_n = ~c_io;
  assign bus.ai_n = ~c_ai;
  assign bus.ao_n = ~c_ao;
  assign bus.eo_n = ~c_eo;
  assign bus.bi_n = ~c_bi;
  assign bus.oi_n = ~c_oi;
  assign bus.co_n = ~c_co;
  assign bus.j_n  = ~c_j;
  assign bus.fi_n = ~c_fi;
  assign bus.ri   = c_ri;
  assign bus.su   = c_su;
  assign bus.ce   = c_ce;
  assign bus.hlt  = halt_q | c_hlt;
  assign bus.step = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a reference model of the step
// counter, halt latch and opcode table produces the expected control vector,
// which is queued when stimulus is applied and compared once outputs settle.
module tb_control_sequencer;

  logic clk = 1'b0;
  logic clr;

  control_sequencer_if bus ();

  control_sequencer dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int          n_vec  = 0;
  int          n_err  = 0;
  int          m_step = 0;
  bit          m_halt = 1'b0;
  logic [18:0] sb_q[$];

  // Expected {step, 12 active-low controls, ri, su, ce, hlt}
  function automatic logic [18:0] model_out();
    logic mi, ro, ii, io, ai, ao, eo, bi, oi, co, j, fi, ri, su, ce, h;
    {mi, ro, ii, io, ai, ao, eo, bi, oi, co, j, fi, ri, su, ce, h} = '0;
    if (m_halt) begin
      h = 1'b1;
    end else if (!clr && bus.prog_mode) begin
      if (m_step == 0) begin
        co = 1'b1; mi = 1'b1;
      end else if (m_step == 1) begin
        ro = 1'b1; ii = 1'b1; ce = 1'b1;
      end else begin
        case (bus.opcode)
          4'h1: if (m_step == 2) begin io = 1'b1; mi = 1'b1; end
                else if (m_step == 3) begin ro = 1'b1; ai = 1'b1; end
          4'h2, 4'h3: begin
            if (m_step == 2) begin io = 1'b1; mi = 1'b1; end
            if (m_step == 3) begin ro = 1'b1; bi = 1'b1; end
            if (m_step == 4) begin
              eo = 1'b1; ai = 1'b1; fi = 1'b1;
              su = (bus.opcode == 4'h3);
            end
          end
          4'h4: if (m_step == 2) begin io = 1'b1; mi = 1'b1; end
                else if (m_step == 3) begin ao = 1'b1; ri = 1'b1; end
          4'h5: if (m_step == 2) begin io = 1'b1; ai = 1'b1; end
          4'h6: if (m_step == 2) begin io = 1'b1; j = 1'b1; end
          4'h7: if (m_step == 2 && bus.carry_flag) begin io = 1'b1; j = 1'b1; end
          4'h8: if (m_step == 2 && bus.zero_flag) begin io = 1'b1; j = 1'b1; end
          4'hE: if (m_step == 2) begin ao = 1'b1; oi = 1'b1; end
          4'hF: if (m_step == 2) h = 1'b1;
          default: ;
        endcase
      end
    end
    return {3'(m_step), ~mi, ~ro, ~ii, ~io, ~ai, ~ao, ~eo, ~bi, ~oi, ~co, ~j, ~fi,
            ri, su, ce, h};
  endfunction

  function automatic logic [18:0] dut_vec();
    return {bus.step, bus.mi_n, bus.ro_n, bus.ii_n, bus.io_n, bus.ai_n, bus.ao_n,
            bus.eo_n, bus.bi_n, bus.oi_n, bus.co_n, bus.j_n, bus.fi_n,
            bus.ri, bus.su, bus.ce, bus.hlt};
  endfunction

  // Model of what the rising edge does, evaluated with the pre-edge inputs
  task automatic tick();
    @(posedge clk);
    if (clr) begin
      m_step = 0;
      m_halt = 1'b0;
    end else if (m_halt) begin
      m_step = 3;
    end else if (!bus.prog_mode) begin
      m_step = 0;
    end else if (m_step == 2 && bus.opcode == 4'hF) begin
      m_halt = 1'b1;
      m_step = 3;
    end else begin
      m_step = (m_step == 4) ? 0 : m_step + 1;
    end
    #1;
  endtask

  task automatic set_clr(input logic v);
    clr = v;
    if (v) begin
      m_step = 0;
      m_halt = 1'b0;
    end
  endtask

  task automatic check(input string tag);
    logic [18:0] exp_v;
    logic [18:0] obs_v;
    int          drv;
    sb_q.push_back(model_out());
    #1;
    exp_v = sb_q.pop_front();
    obs_v = dut_vec();
    n_vec++;
    assert (obs_v === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs_v, exp_v);
    end
    drv = $countones({~bus.co_n, ~bus.ro_n, ~bus.io_n, ~bus.ao_n, ~bus.eo_n});
    n_vec++;
    assert (drv <= 1) else begin
      n_err++;
      $error("FAIL %s_bus_drivers observed=%0d expected<=1", tag, drv);
    end
  endtask

  task automatic run_instr(input logic [3:0] op, input string tag);
    bus.opcode = op;
    for (int s = 0; s < 5; s++) begin
      check($sformatf("%s_t%0d", tag, s));
      tick();
    end
  endtask

  initial begin
    bus.prog_mode  = 1'b1;
    bus.opcode     = 4'h1;
    bus.carry_flag = 1'b0;
    bus.zero_flag  = 1'b0;
    set_clr(1'b1);
    #2;
    check("reset_hold");
    tick();
    check("reset_hold_edge");
    #2;
    set_clr(1'b0);
    check("t0_after_clr");

    run_instr(4'h1, "lda");
    check("lda_wrap");
    run_instr(4'h2, "add");
    run_instr(4'h3, "sub");
    run_instr(4'h4, "sta");
    run_instr(4'h5, "ldi");
    run_instr(4'h6, "jmp");
    bus.carry_flag = 1'b0;
    run_instr(4'h7, "jc_c0");
    bus.carry_flag = 1'b1;
    run_instr(4'h7, "jc_c1");
    bus.zero_flag = 1'b1;
    run_instr(4'h8, "jz_z1");
    bus.zero_flag = 1'b0;
    run_instr(4'h8, "jz_z0");
    run_instr(4'hE, "out");
    run_instr(4'h0, "nop");
    run_instr(4'hA, "undef");

    // Flag changes inside T2 act combinationally
    bus.opcode     = 4'h7;
    bus.carry_flag = 1'b0;
    check("jcm_t0"); tick();
    check("jcm_t1"); tick();
    check("jcm_t2_c0");
    bus.carry_flag = 1'b1;
    check("jcm_t2_c1");
    bus.opcode = 4'h5;
    check("jcm_t2_op_ldi");
    tick(); check("jcm_t3");
    tick(); check("jcm_t4");
    tick(); check("jcm_wrap");

    // STA abandoned at T3 by dropping to program mode
    bus.opcode = 4'h4;
    tick(); check("sta_ab_t1");
    tick(); check("sta_ab_t2");
    tick(); check("sta_ab_t3");
    bus.prog_mode = 1'b0;
    check("sta_ab_prog0");
    tick(); check("prog0_step0");
    tick(); check("prog0_hold");
    bus.prog_mode = 1'b1;
    check("prog1_t0");
    tick(); check("prog1_t1");
    tick(); tick(); tick(); tick();
    check("prog1_wrap");

    // Halt
    bus.opcode = 4'hF;
    check("hlt_t0"); tick();
    check("hlt_t1"); tick();
    check("hlt_t2"); tick();
    for (int i = 0; i < 20; i++) begin
      check($sformatf("halted_%0d", i));
      tick();
    end
    bus.prog_mode = 1'b0;
    check("halted_prog0"); tick();
    check("halted_prog0_edge");
    bus.prog_mode = 1'b1;
    check("halted_prog1"); tick();
    check("halted_prog1_edge");
    #2;
    set_clr(1'b1);
    check("hlt_clr");
    #2;
    set_clr(1'b0);
    check("hlt_released");

    // Asynchronous clear in the middle of T2
    bus.opcode = 4'h1;
    tick(); check("clrm_t1");
    tick(); check("clrm_t2");
    set_clr(1'b1);
    check("clr_mid_t2");
    tick(); check("clr_held_edge");
    #2;
    set_clr(1'b0);
    check("clr_release_t0");
    tick(); check("clr_release_t1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
